demux_1_to_8_6_bit_reg: RTL and testbench
=========================================

# demux_1_to_8_6_bit_reg

Write-side counterpart of the 8-to-1 6-bit read multiplexer: accepts one 6-bit write command per handshake and steers it into one of eight 6-bit registers selected by a 3-bit address. All eight registers are driven out in parallel as the data inputs `i0`..`i7` of the existing `mux_8_to_1_6_bit`, forming the CPU's register bank. Supports load, increment and a multi-cycle clear-all sweep.

## Interface
Parameters:
- `WIDTH`, 6: data width of each register.
- `DEPTH`, 8: register count, fixed at 8 because `wr_addr` is 3 bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_valid`  in  1  command present.
- `wr_ready`  out  1  block can accept a command this cycle.
- `wr_op`  in  2  operation: 00 LOAD, 01 INC, 10 CLEAR_ALL, 11 NOP.
- `wr_addr`  in  3  target register for LOAD/INC.
- `wr_data`  in  WIDTH  data for LOAD.
- `q0`..`q7`  out  WIDTH each  register contents, to mux `i0`..`i7`.
- `dirty`  out  8  bit k set when `qk` was written since the last reset or clear.
- `busy`  out  1  CLEAR_ALL sweep in progress.
- `ovf`  out  1  one-cycle pulse when an INC wraps 63 to 0.

## Operation
- Command is accepted on a rising edge where `wr_valid && wr_ready`. Otherwise inputs are ignored.
- `wr_ready = !busy`. It is purely combinational from state and never depends on `wr_valid`.
- LOAD: `q[wr_addr] <= wr_data`; `dirty[wr_addr] <= 1`.
- INC: `q[wr_addr] <= q[wr_addr] + 1` modulo 64; `dirty[wr_addr] <= 1`. When the old value is 63, result is 0 and `ovf` pulses for one cycle.
- CLEAR_ALL: enter state CLEAR with sweep counter `cnt = 0`. Each CLEAR cycle zeroes `q[cnt]` and `dirty[cnt]`, then increments `cnt`. After the cycle with `cnt = 7`, return to IDLE.
- NOP: accepted (handshake completes), no state change.
- Only the addressed register changes on LOAD/INC; the other seven hold.
- FSM:
  - IDLE → CLEAR on accepted CLEAR_ALL.
  - CLEAR → CLEAR while `cnt < 7`.
  - CLEAR → IDLE after `cnt = 7`.
  - No other states.
- During CLEAR, registers with index ≥ `cnt` keep their values until swept. The mux may read partially cleared contents, and this is legal.

## Timing
- Reset (`rst_n = 0` at a rising edge):
  - `q0`..`q7 = 0`, `dirty = 0`, `busy = 0`, `ovf = 0`, `wr_ready = 1`, state IDLE, `cnt = 0`.
- Reset mid-sweep aborts CLEAR immediately with the same values. No command is accepted on a reset edge.
- LOAD/INC latency is 1 cycle: the new `q` is visible after the accepting edge. `ovf` is asserted for the cycle following that edge only.
- CLEAR_ALL timing:
  - `busy` rises after the accepting edge and is high for exactly 8 cycles.
  - `wr_ready` is low for those 8 cycles.
  - The next command can be accepted on the 9th edge after acceptance.
- Back-to-back LOAD/INC are accepted every cycle with no bubble. An INC to a register loaded on the previous edge uses the updated value.
- `wr_valid` held high while `wr_ready = 0`: nothing happens; the command is accepted once `wr_ready` returns. The sender must hold its inputs stable until then.

## Structure
- Shared package `cpu6_pkg`:
  - `WIDTH = 6`, `DEPTH = 8`.
  - Op encodings `OP_LOAD`, `OP_INC`, `OP_CLEAR`, `OP_NOP`.
  - FSM state encodings `ST_IDLE`, `ST_CLEAR`.
- Sub-module `decoder_3_to_8`: combinational one-hot decode of a 3-bit index with an enable input. It is used twice: for `wr_addr` gated by accept, and for `cnt` gated by CLEAR.
- Per-register next-value logic lives in the top level. Outputs `q0`..`q7` are driven directly from flops.

## Test plan
- Reset, then LOAD i → data i for addr 0..4 (values 0..4), sweep mux `sel` 0..7 → mux `out` = 0,1,2,3,4,0,0,0; `dirty` = 8'b0001_1111.
- LOAD addr 6 = 62, then INC addr 6 on the next cycle, then INC again → `q6` = 63 then 0; `ovf` high only in the cycle after the second INC.
- LOAD all eight with 45, issue CLEAR_ALL with `wr_valid` held and a LOAD addr 2 = 9 queued:
  - `busy` = 1 for 8 cycles; `q0` = 0 one cycle after acceptance, `q7` = 0 eight cycles after.
  - LOAD accepted on the 9th edge → `q2` = 9, `dirty` = 8'b0000_0100.
- Assert `rst_n` = 0 on the 4th CLEAR cycle → next cycle all `q` = 0, `busy` = 0, `wr_ready` = 1.
- `wr_valid` = 0 with `wr_op` = LOAD, `wr_data` = 7 on every address → no register or `dirty` change. NOP with `wr_valid` = 1 → handshake completes, no change.

Source files
------------

// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU register bank.
//   WIDTH / DEPTH : register width and count
//   op_e          : write-command operation codes
//   state_e       : write-side FSM states
//   inc_wrap      : modulo-2^WIDTH increment used by INC
package cpu6_pkg;

    localparam int WIDTH = 6;
    localparam int DEPTH = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Natural wrap of a WIDTH-bit add gives the modulo-64 behaviour.
    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
        return v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/demux_1_to_8_6_bit_reg_if.sv
// Write-command handshake bundle for the register bank.
//   wr_valid : command present          (master -> slave)
//   wr_ready : bank can accept          (slave  -> master)
//   wr_op    : LOAD / INC / CLEAR / NOP (master -> slave)
//   wr_addr  : target register          (master -> slave)
//   wr_data  : LOAD data                (master -> slave)
interface demux_1_to_8_6_bit_reg_if #(
    parameter int WIDTH = cpu6_pkg::WIDTH
);
    logic               wr_valid;
    logic               wr_ready;
    cpu6_pkg::op_e      wr_op;
    logic [2:0]         wr_addr;
    logic [WIDTH-1:0]   wr_data;

    modport master (
        output wr_valid, wr_op, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_op, wr_addr, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/demux_1_to_8_6_bit_reg_decoder_3_to_8.sv
// One-hot decode of a 3-bit index with an enable.
//   en     : when low, all outputs are low
//   idx    : index to decode
//   onehot : bit idx set when en is high
module decoder_3_to_8 (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] onehot
);
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        assign onehot[gi] = en && (idx == 3'(gi));
    end
endmodule

// File: rtl/demux_1_to_8_6_bit_reg.sv
// Eight-entry 6-bit register bank, write side of the 8-to-1 read mux.
// Accepts one command per handshake: LOAD, INC (wrapping, with ovf pulse),
// CLEAR_ALL (eight-cycle sweep, one register per cycle) and NOP.
//   clk, rst_n : clock, synchronous active-low reset
//   wr         : command handshake (slave modport)
//   q0..q7     : register contents, straight from flops
//   dirty      : per-register written-since-reset/clear flags
//   busy       : clear sweep in progress
//   ovf        : one-cycle pulse when an INC wrapped 63 -> 0
module demux_1_to_8_6_bit_reg #(
    parameter int WIDTH = cpu6_pkg::WIDTH,
    parameter int DEPTH = cpu6_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    demux_1_to_8_6_bit_reg_if.slave     wr,
    output logic [WIDTH-1:0]            q0,
    output logic [WIDTH-1:0]            q1,
    output logic [WIDTH-1:0]            q2,
    output logic [WIDTH-1:0]            q3,
    output logic [WIDTH-1:0]            q4,
    output logic [WIDTH-1:0]            q5,
    output logic [WIDTH-1:0]            q6,
    output logic [WIDTH-1:0]            q7,
    output logic [DEPTH-1:0]            dirty,
    output logic                        busy,
    output logic                        ovf
);
    import cpu6_pkg::*;

    state_e             state_reg, state_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [WIDTH-1:0]   q_reg  [DEPTH];
    logic [WIDTH-1:0]   q_next [DEPTH];
    logic [DEPTH-1:0]   dirty_reg, dirty_next;
    logic               ovf_reg, ovf_next;

    logic               in_clear;
    logic               accept;
    logic               wr_en;
    logic [DEPTH-1:0]   wr_sel;
    logic [DEPTH-1:0]   clr_sel;

    assign in_clear    = (state_reg == ST_CLEAR);
    assign wr.wr_ready = !in_clear;
    assign accept      = wr.wr_valid && !in_clear;
    // Only LOAD and INC target a single register.
    assign wr_en       = accept && (wr.wr_op == OP_LOAD || wr.wr_op == OP_INC);

    decoder_3_to_8 u_wr_dec (
        .en     (wr_en),
        .idx    (wr.wr_addr),
        .onehot (wr_sel)
    );

    decoder_3_to_8 u_clr_dec (
        .en     (in_clear),
        .idx    (cnt_reg),
        .onehot (clr_sel)
    );

    // Per-register next value. wr_sel and clr_sel are mutually exclusive
    // because writes are only accepted outside the sweep.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        assign q_next[gi] = clr_sel[gi]            ? '0 :
                            !wr_sel[gi]            ? q_reg[gi] :
                            (wr.wr_op == OP_LOAD)  ? wr.wr_data :
                                                     inc_wrap(q_reg[gi]);
        assign dirty_next[gi] = clr_sel[gi] ? 1'b0 :
                                wr_sel[gi]  ? 1'b1 : dirty_reg[gi];
    end

    assign ovf_next = accept && (wr.wr_op == OP_INC)
                      && (q_reg[wr.wr_addr] == {WIDTH{1'b1}});

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && wr.wr_op == OP_CLEAR) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                // cnt wraps back to 0 on the last sweep cycle.
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dirty_reg <= '0;
            ovf_reg   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dirty_reg <= dirty_next;
            ovf_reg   <= ovf_next;
            for (int i = 0; i < DEPTH; i++) begin
                q_reg[i] <= q_next[i];
            end
        end
    end

    assign q0    = q_reg[0];
    assign q1    = q_reg[1];
    assign q2    = q_reg[2];
    assign q3    = q_reg[3];
    assign q4    = q_reg[4];
    assign q5    = q_reg[5];
    assign q6    = q_reg[6];
    assign q7    = q_reg[7];
    assign dirty = dirty_reg;
    assign busy  = in_clear;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_demux_1_to_8_6_bit_reg.sv
module tb_demux_1_to_8_6_bit_reg;
    import cpu6_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_1_to_8_6_bit_reg_if bus ();

    logic [5:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0] dirty;
    logic       busy, ovf;

    demux_1_to_8_6_bit_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (bus.slave),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3),
        .q4    (q4),
        .q5    (q5),
        .q6    (q6),
        .q7    (q7),
        .dirty (dirty),
        .busy  (busy),
        .ovf   (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read port of the downstream 8-to-1 mux, fed from the bank outputs.
    function automatic int mux_read(input int sel);
        case (sel)
            0: return int'(q0);
            1: return int'(q1);
            2: return int'(q2);
            3: return int'(q3);
            4: return int'(q4);
            5: return int'(q5);
            6: return int'(q6);
            default: return int'(q7);
        endcase
    endfunction

    // Behavioural model: register array, dirty flags, and a count of
    // remaining sweep cycles instead of an explicit state machine.
    int m_q [8];
    bit [7:0] m_dirty;
    int m_left;
    int m_idx;
    bit m_ovf;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_q[i] = 0;
            m_dirty = '0;
            m_left  = 0;
            m_idx   = 0;
            m_ovf   = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (m_left > 0) begin
                m_q[m_idx]     = 0;
                m_dirty[m_idx] = 1'b0;
                m_idx++;
                m_left--;
            end else if (bus.wr_valid) begin
                $display("txn t=%0t op=%0d addr=%0d data=%0d",
                         $time, bus.wr_op, bus.wr_addr, bus.wr_data);
                case (bus.wr_op)
                    OP_LOAD: begin
                        m_q[bus.wr_addr]     = int'(bus.wr_data);
                        m_dirty[bus.wr_addr] = 1'b1;
                    end
                    OP_INC: begin
                        if (m_q[bus.wr_addr] == 63) m_ovf = 1'b1;
                        m_q[bus.wr_addr]     = (m_q[bus.wr_addr] + 1) % 64;
                        m_dirty[bus.wr_addr] = 1'b1;
                    end
                    OP_CLEAR: begin
                        m_left = 8;
                        m_idx  = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare process: all outputs against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("model_q%0d", i), mux_read(i), m_q[i]);
            check("model_dirty", int'(dirty), int'(m_dirty));
            check("model_busy", int'(busy), (m_left > 0) ? 1 : 0);
            check("model_ready", int'(bus.wr_ready), (m_left == 0) ? 1 : 0);
            check("model_ovf", int'(ovf), int'(m_ovf));
        end
    end

    // Present a command at a negedge and hold it until an edge accepts it.
    // Returns at the negedge following the accepting edge.
    task automatic send(input op_e op, input int addr, input int data);
        bit acc;
        acc = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_op    = op;
        bus.wr_addr  = 3'(addr);
        bus.wr_data  = 6'(data);
        for (int t = 0; t < 40 && !acc; t++) begin
            acc = bus.wr_ready;
            @(negedge clk);
        end
        if (!acc) check("send_timeout", 0, 1);
        bus.wr_valid = 1'b0;
    endtask

    int mux_exp [8] = '{0, 1, 2, 3, 4, 0, 0, 0};
    int busy_cycles;

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_op    = OP_NOP;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 6'd0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_dirty", int'(dirty), 0);
        check("reset_q3", int'(q3), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(bus.wr_ready), 1);
        check("reset_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Load 0..4 into addresses 0..4, then read every mux input.
        for (int i = 0; i < 5; i++) send(OP_LOAD, i, i);
        for (int s = 0; s < 8; s++)
            check($sformatf("mux_sel%0d", s), mux_read(s), mux_exp[s]);
        check("dirty_after_loads", int'(dirty), 8'b0001_1111);

        // Wrap test on register 6.
        send(OP_LOAD, 6, 62);
        send(OP_INC, 6, 0);
        check("q6_first_inc", int'(q6), 63);
        check("ovf_first_inc", int'(ovf), 0);
        send(OP_INC, 6, 0);
        check("q6_wrap", int'(q6), 0);
        check("ovf_wrap", int'(ovf), 1);
        @(negedge clk);
        check("ovf_one_cycle", int'(ovf), 0);

        // Clear sweep with a LOAD queued behind it.
        for (int i = 0; i < 8; i++) send(OP_LOAD, i, 45);
        bus.wr_valid = 1'b1;
        bus.wr_op    = OP_CLEAR;
        @(negedge clk);
        bus.wr_op   = OP_LOAD;
        bus.wr_addr = 3'd2;
        bus.wr_data = 6'd9;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cycles++;
            if (i == 0) check("q0_before_sweep", int'(q0), 45);
            if (i == 1) check("q0_swept", int'(q0), 0);
            if (i == 1) check("q7_not_yet", int'(q7), 45);
            @(negedge clk);
        end
        check("busy_cycles", busy_cycles, 8);
        check("busy_done", int'(busy), 0);
        check("q7_swept", int'(q7), 0);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("queued_q2", int'(q2), 9);
        check("queued_dirty", int'(dirty), 8'b0000_0100);

        // Reset on the fourth sweep cycle.
        send(OP_LOAD, 5, 33);
        send(OP_LOAD, 7, 21);
        bus.wr_valid = 1'b1;
        bus.wr_op    = OP_CLEAR;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_q5", int'(q5), 0);
        check("abort_q7", int'(q7), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(bus.wr_ready), 1);
        rst_n = 1'b1;

        // Unqualified commands and NOP leave the bank alone.
        send(OP_LOAD, 1, 12);
        bus.wr_valid = 1'b0;
        bus.wr_op    = OP_LOAD;
        bus.wr_data  = 6'd7;
        for (int a = 0; a < 8; a++) begin
            bus.wr_addr = 3'(a);
            @(negedge clk);
        end
        check("novalid_q1", int'(q1), 12);
        check("novalid_q0", int'(q0), 0);
        check("novalid_dirty", int'(dirty), 8'b0000_0010);
        send(OP_NOP, 3, 50);
        check("nop_q3", int'(q3), 0);
        check("nop_dirty", int'(dirty), 8'b0000_0010);
        @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
